dmem_responder: RTL and testbench

- Memory-side responder for the pipelined CPU's data-memory port, placed on the far side of a valid/ready request/response interface.
- Models a word-organised data RAM with a configurable access latency.
- Used to bring up and verify the CPU's stall and wait-state handling against a non-ideal memory.
- Services exactly one outstanding transaction at a time.

---
 rtl/dmem_if.sv | 24 ++
 rtl/dmem_responder.sv | 123 ++++++++++++
 tb/tb_dmem_responder.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// Valid/ready request/response bus between the CPU data port (master)
// and the data-memory responder (slave).
interface dmem_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [3:0]  req_be;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data RAM behind a valid/ready port with a fixed number of
// wait cycles between accept and access; one transaction in flight at a time.
module dmem_responder #(
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 2
) (
   input  logic  Clk,
   input  logic  Clrn,
   dmem_if.slave bus,
   output logic  busy
);
   localparam int         DEPTH    = 1 << ADDR_W;
   localparam logic [3:0] LAT_INIT = LATENCY[3:0];

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [3:0]          r_cnt;
   logic                r_we;
   logic [31:0]         r_addr;
   logic [3:0]          r_be;
   logic [31:0]         r_wdata;
   logic                r_rsp_valid;
   logic [31:0]         r_rsp_rdata;
   logic                r_rsp_err;
   logic [31:0]         r_mem [0:DEPTH-1];
   logic                w_accept;
   logic                w_access;
   logic                w_handshake;
   logic                w_err;
   logic [ADDR_W-1:0]   w_idx;

   // Misaligned or beyond the RAM's word range.
   function automatic logic addr_err(input logic [31:0] addr);
      return (addr[1:0] != 2'd0) || ((addr >> (ADDR_W + 2)) != 32'd0);
   endfunction

   assign w_accept    = (r_state == S_IDLE) && bus.req_valid;
   assign w_access    = (r_state == S_WAIT) && (r_cnt == 4'd0);
   assign w_handshake = (r_state == S_RESP) && r_rsp_valid && bus.rsp_ready;
   assign w_err       = addr_err(r_addr);
   assign w_idx       = r_addr[ADDR_W+1:2];

   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_rdata = r_rsp_rdata;
   assign bus.rsp_err   = r_rsp_err;

   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept)        w_next = S_WAIT; else w_next = S_IDLE;
         S_WAIT:  if (r_cnt == 4'd0)   w_next = S_RESP; else w_next = S_WAIT;
         S_RESP:  if (w_handshake)     w_next = S_IDLE; else w_next = S_RESP;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready = 1'b0;
      busy          = 1'b1;
      case (r_state)
         S_IDLE:  begin bus.req_ready = 1'b1; busy = 1'b0; end
         default: begin bus.req_ready = 1'b0; busy = 1'b1; end
      endcase
   end

   // Request latch, wait counter and response registers; a reset drops any
   // pending transaction without issuing its response.
   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         r_cnt       <= 4'd0;
         r_we        <= 1'b0;
         r_addr      <= 32'd0;
         r_be        <= 4'd0;
         r_wdata     <= 32'd0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 32'd0;
         r_rsp_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_we    <= bus.req_we;
            r_addr  <= bus.req_addr;
            r_be    <= bus.req_be;
            r_wdata <= bus.req_wdata;
            r_cnt   <= LAT_INIT;
         end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_access) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_err;
            r_rsp_rdata <= (w_err || r_we) ? 32'd0 : r_mem[w_idx];
         end else if (w_handshake) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
         end
      end
   end

   // RAM contents survive reset; only enabled bytes of a clean store change.
   always_ff @(posedge Clk) begin
      if (w_access && r_we && !w_err) begin
         for (int b = 0; b < 4; b++) begin
            if (r_be[b]) begin
               r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
            end
         end
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table on a LATENCY=2 instance plus
// hand sequences for backpressure, LATENCY=0 throughput and reset mid-transaction.
module tb_dmem_responder;
   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   localparam int NV = 15;

   logic clk = 1'b0;
   logic rst_n;
   logic busy2, busy0, busy4;
   int   n_pass  = 0;
   int   n_total = 0;
   vec_t vecs [NV];

   always #5 clk = ~clk;

   dmem_if if2();
   dmem_if if0();
   dmem_if if4();

   dmem_responder #(.ADDR_W(8), .LATENCY(2)) u_dut2 (.Clk(clk), .Clrn(rst_n), .bus(if2), .busy(busy2));
   dmem_responder #(.ADDR_W(8), .LATENCY(0)) u_dut0 (.Clk(clk), .Clrn(rst_n), .bus(if0), .busy(busy0));
   dmem_responder #(.ADDR_W(8), .LATENCY(4)) u_dut4 (.Clk(clk), .Clrn(rst_n), .bus(if4), .busy(busy4));

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: actual %h, required %h", name, act, exp);
      else n_pass++;
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: actual %b, required %b", name, act, exp);
      else n_pass++;
   endtask

   // One full transaction on the LATENCY=2 instance, corrupting req_* after accept.
   task automatic run_txn(input vec_t v, input int i);
      int lat;
      @(negedge clk);
      check1($sformatf("v%0d req_ready", i), if2.req_ready, 1'b1);
      if2.req_valid = 1'b1; if2.req_we = v.we; if2.req_addr = v.addr;
      if2.req_be = v.be; if2.req_wdata = v.wdata; if2.rsp_ready = 1'b0;
      @(negedge clk);
      if2.req_valid = 1'b0; if2.req_we = ~v.we; if2.req_addr = ~v.addr;
      if2.req_be = ~v.be; if2.req_wdata = ~v.wdata;
      check1($sformatf("v%0d busy", i), busy2, 1'b1);
      lat = 0;
      while (!if2.rsp_valid && lat < 20) begin @(negedge clk); lat++; end
      check32($sformatf("v%0d latency", i), 32'(lat), 32'd3);
      check32($sformatf("v%0d rdata", i), if2.rsp_rdata, v.exp_rdata);
      check1($sformatf("v%0d err", i), if2.rsp_err, v.exp_err);
      if2.rsp_ready = 1'b1;
      @(negedge clk);
      if2.rsp_ready = 1'b0;
      check1($sformatf("v%0d valid drop", i), if2.rsp_valid, 1'b0);
      check1($sformatf("v%0d err drop", i), if2.rsp_err, 1'b0);
      check1($sformatf("v%0d ready back", i), if2.req_ready, 1'b1);
      check32($sformatf("v%0d rdata kept", i), if2.rsp_rdata, v.exp_rdata);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: actual timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int   lat;
      logic seen;
      vec_t tv;
      rst_n = 1'b0;
      if2.req_valid = 1'b0; if2.req_we = 1'b0; if2.req_addr = 32'd0; if2.req_be = 4'd0; if2.req_wdata = 32'd0; if2.rsp_ready = 1'b0;
      if0.req_valid = 1'b0; if0.req_we = 1'b0; if0.req_addr = 32'd0; if0.req_be = 4'd0; if0.req_wdata = 32'd0; if0.rsp_ready = 1'b0;
      if4.req_valid = 1'b0; if4.req_we = 1'b0; if4.req_addr = 32'd0; if4.req_be = 4'd0; if4.req_wdata = 32'd0; if4.rsp_ready = 1'b0;

      vecs[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
      vecs[1]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
      vecs[2]  = '{1'b1, 32'h0000_0004, 4'hF, 32'h1122_3344, 32'h0000_0000, 1'b0};
      vecs[3]  = '{1'b1, 32'h0000_0004, 4'h5, 32'hAABB_CCDD, 32'h0000_0000, 1'b0};
      vecs[4]  = '{1'b0, 32'h0000_0004, 4'h0, 32'h0000_0000, 32'h11BB_33DD, 1'b0};
      vecs[5]  = '{1'b1, 32'h0000_0004, 4'h0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
      vecs[6]  = '{1'b0, 32'h0000_0004, 4'h0, 32'h0000_0000, 32'h11BB_33DD, 1'b0};
      vecs[7]  = '{1'b0, 32'h0000_0002, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1};
      vecs[8]  = '{1'b1, 32'h0000_0000, 4'hF, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
      vecs[9]  = '{1'b1, 32'h0000_0400, 4'hF, 32'h5555_5555, 32'h0000_0000, 1'b1};
      vecs[10] = '{1'b0, 32'h0000_0000, 4'h0, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
      vecs[11] = '{1'b1, 32'h0000_03FC, 4'hF, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0};
      vecs[12] = '{1'b0, 32'h0000_03FC, 4'h0, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0};
      vecs[13] = '{1'b0, 32'h8000_0000, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1};
      vecs[14] = '{1'b0, 32'h0000_0001, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1};

      repeat (3) @(posedge clk);
      #1;
      check1("rst req_ready", if2.req_ready, 1'b1);
      check1("rst busy", busy2, 1'b0);
      check1("rst rsp_valid", if2.rsp_valid, 1'b0);
      check32("rst rsp_rdata", if2.rsp_rdata, 32'd0);
      check1("rst rsp_err", if2.rsp_err, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) run_txn(vecs[i], i);

      // Backpressure with a second request already waiting.
      @(negedge clk);
      if2.req_valid = 1'b1; if2.req_we = 1'b0; if2.req_addr = 32'h10; if2.req_be = 4'h0; if2.rsp_ready = 1'b0;
      @(negedge clk);
      if2.req_addr = 32'h4;
      lat = 0;
      while (!if2.rsp_valid && lat < 20) begin @(negedge clk); lat++; end
      check32("bp latency", 32'(lat), 32'd3);
      for (int k = 0; k < 5; k++) begin
         check1($sformatf("bp%0d valid", k), if2.rsp_valid, 1'b1);
         check32($sformatf("bp%0d rdata", k), if2.rsp_rdata, 32'hDEAD_BEEF);
         check1($sformatf("bp%0d err", k), if2.rsp_err, 1'b0);
         check1($sformatf("bp%0d req_ready", k), if2.req_ready, 1'b0);
         @(negedge clk);
      end
      if2.rsp_ready = 1'b1;
      @(negedge clk);
      if2.rsp_ready = 1'b0;
      check1("bp hs valid", if2.rsp_valid, 1'b0);
      check1("bp hs ready", if2.req_ready, 1'b1);
      check1("bp hs busy", busy2, 1'b0);
      @(negedge clk);
      if2.req_valid = 1'b0;
      check1("bp 2nd busy", busy2, 1'b1);
      check1("bp 2nd ready", if2.req_ready, 1'b0);
      lat = 0;
      while (!if2.rsp_valid && lat < 20) begin @(negedge clk); lat++; end
      check32("bp 2nd latency", 32'(lat), 32'd3);
      check32("bp 2nd rdata", if2.rsp_rdata, 32'h11BB_33DD);
      if2.rsp_ready = 1'b1;
      @(negedge clk);
      if2.rsp_ready = 1'b0;
      check1("bp 2nd drop", if2.rsp_valid, 1'b0);

      // LATENCY=0, continuous requests: accept every third edge.
      @(negedge clk);
      if0.req_valid = 1'b1; if0.req_we = 1'b0; if0.req_addr = 32'h0; if0.rsp_ready = 1'b1;
      for (int k = 0; k < 9; k++) begin
         check1($sformatf("l0 k%0d ready", k), if0.req_ready, (k % 3 == 0));
         check1($sformatf("l0 k%0d valid", k), if0.rsp_valid, (k % 3 == 2));
         check1($sformatf("l0 k%0d busy", k), busy0, (k % 3 != 0));
         @(negedge clk);
      end
      if0.req_valid = 1'b0;

      // LATENCY=4: place a known word, then reset during WAIT of a store over it.
      if4.req_valid = 1'b1; if4.req_we = 1'b1; if4.req_addr = 32'h8; if4.req_be = 4'hF; if4.req_wdata = 32'hAAAA_AAAA;
      @(negedge clk);
      if4.req_valid = 1'b0;
      lat = 0;
      while (!if4.rsp_valid && lat < 30) begin @(negedge clk); lat++; end
      check32("l4 latency", 32'(lat), 32'd5);
      check32("l4 store rdata", if4.rsp_rdata, 32'd0);
      if4.rsp_ready = 1'b1;
      @(negedge clk);
      if4.rsp_ready = 1'b0;
      if4.req_valid = 1'b1; if4.req_wdata = 32'h1234_5678;
      @(posedge clk);
      @(negedge clk);
      if4.req_valid = 1'b0;
      check1("l4 wait busy", busy4, 1'b1);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check1("l4 rst ready", if4.req_ready, 1'b1);
      check1("l4 rst busy", busy4, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (if4.rsp_valid) seen = 1'b1;
      end
      check1("l4 no response", seen, 1'b0);
      check1("l4 idle ready", if4.req_ready, 1'b1);
      if4.req_valid = 1'b1; if4.req_we = 1'b0;
      @(negedge clk);
      if4.req_valid = 1'b0;
      lat = 0;
      while (!if4.rsp_valid && lat < 30) begin @(negedge clk); lat++; end
      check32("l4 load latency", 32'(lat), 32'd5);
      check32("l4 ram unchanged", if4.rsp_rdata, 32'hAAAA_AAAA);
      if4.rsp_ready = 1'b1;
      @(negedge clk);
      if4.rsp_ready = 1'b0;

      // Reset while a performed store waits in RESP: RAM keeps it, response dropped.
      if2.req_valid = 1'b1; if2.req_we = 1'b1; if2.req_addr = 32'h20; if2.req_be = 4'hF; if2.req_wdata = 32'h0BAD_CAFE;
      @(negedge clk);
      if2.req_valid = 1'b0;
      lat = 0;
      while (!if2.rsp_valid && lat < 20) begin @(negedge clk); lat++; end
      check32("pr latency", 32'(lat), 32'd3);
      rst_n = 1'b0;
      #1;
      check1("pr rst valid", if2.rsp_valid, 1'b0);
      check1("pr rst ready", if2.req_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      tv = '{1'b0, 32'h0000_0020, 4'h0, 32'h0000_0000, 32'h0BAD_CAFE, 1'b0};
      run_txn(tv, 99);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
